// File: rtl/brief_lb_seq_if.sv
// BRIEF line-buffer sequencer bus: raster pixel stream in,
// SRAM port control and window-centre tracking out.
interface brief_lb_seq_if;
   logic       i_pixel_valid;
   logic       i_start;
   logic [7:0] i_pixel;
   logic       o_sram_wen;
   logic [9:0] o_sram_addr_wr;
   logic [9:0] o_sram_addr_rd;
   logic [7:0] o_sram_d;
   logic       o_win_valid;
   logic [9:0] o_coor_x;
   logic [9:0] o_coor_y;
   logic       o_start;
   logic       o_end;
   logic       o_busy;

   modport master (
      output i_pixel_valid, i_start, i_pixel,
      input  o_sram_wen, o_sram_addr_wr, o_sram_addr_rd, o_sram_d,
      input  o_win_valid, o_coor_x, o_coor_y,
      input  o_start, o_end, o_busy
   );

   modport slave (
      input  i_pixel_valid, i_start, i_pixel,
      output o_sram_wen, o_sram_addr_wr, o_sram_addr_rd, o_sram_d,
      output o_win_valid, o_coor_x, o_coor_y,
      output o_start, o_end, o_busy
   );
endinterface

// File: rtl/brief_lb_seq.sv
// BRIEF line-buffer sequencer: circular SRAM addressing,
// window fill latency and raster window-centre tracking.
module brief_lb_seq #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int R      = 15
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   brief_lb_seq_if.slave  bus
);
   localparam int FILL_LEN = R * WIDTH + R;
   localparam int NPIX     = WIDTH * HEIGHT;

   localparam logic [9:0]  X_MAX  = 10'(WIDTH - 1);
   localparam logic [9:0]  Y_MAX  = 10'(HEIGHT - 1);
   localparam logic [19:0] FILL_M = 20'(FILL_LEN - 1);
   localparam logic [19:0] NPIX_M = 20'(NPIX - 1);
   localparam logic [19:0] NPIX_C = 20'(NPIX);

   typedef enum logic [1:0] {IDLE, FILL, WORK, FLUSH} state_t;

   state_t      state;
   logic [19:0] in_cnt;
   logic [9:0]  cx, cy;
   logic        wen_q, wv_q, st_q, en_q, busy_q;
   logic [9:0]  wr_q, rd_q, ox_q, oy_q;
   logic [7:0]  d_q;
   logic [9:0]  wr_nx, rd_nx;
   logic        last;

   assign wr_nx = (wr_q == X_MAX) ? '0 : wr_q + 10'd1;
   assign rd_nx = (wr_nx == X_MAX) ? '0 : wr_nx + 10'd1;
   assign last  = (cx == X_MAX) && (cy == Y_MAX);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state  <= IDLE;
         in_cnt <= '0;
         cx     <= '0;
         cy     <= '0;
         wen_q  <= 1'b1;
         wr_q   <= '0;
         rd_q   <= '0;
         d_q    <= '0;
         wv_q   <= 1'b0;
         ox_q   <= '0;
         oy_q   <= '0;
         st_q   <= 1'b0;
         en_q   <= 1'b0;
         busy_q <= 1'b0;
      end else if (!bus.i_pixel_valid) begin
         wen_q <= 1'b1;
         wv_q  <= 1'b0;
         st_q  <= 1'b0;
         en_q  <= 1'b0;
      end else begin
         st_q <= 1'b0;
         en_q <= 1'b0;
         wv_q <= 1'b0;
         ox_q <= '0;
         oy_q <= '0;
         if (bus.i_start) begin
            // restart beats end-of-frame; abort reports o_end too
            st_q   <= 1'b1;
            en_q   <= (state != IDLE);
            state  <= FILL;
            busy_q <= 1'b1;
            in_cnt <= 20'd1;
            wr_q   <= '0;
            rd_q   <= '0;
            wen_q  <= 1'b0;
            d_q    <= bus.i_pixel;
            cx     <= '0;
            cy     <= '0;
         end else if (state == IDLE) begin
            wen_q <= 1'b1;
         end else begin
            wen_q <= 1'b0;
            d_q   <= (state == FLUSH) ? 8'd0 : bus.i_pixel;
            wr_q  <= wr_nx;
            rd_q  <= rd_nx;
            if (in_cnt != NPIX_C)
               in_cnt <= in_cnt + 20'd1;
            unique case (state)
               FILL: begin
                  if (in_cnt == FILL_M)
                     state <= WORK;
               end
               WORK, FLUSH: begin
                  wv_q <= 1'b1;
                  ox_q <= cx;
                  oy_q <= cy;
                  if (last) begin
                     cx     <= '0;
                     cy     <= '0;
                     en_q   <= 1'b1;
                     state  <= IDLE;
                     busy_q <= 1'b0;
                  end else begin
                     if (cx == X_MAX) begin
                        cx <= '0;
                        cy <= cy + 10'd1;
                     end else begin
                        cx <= cx + 10'd1;
                     end
                     if (state == WORK && in_cnt == NPIX_M)
                        state <= FLUSH;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.o_sram_wen     = wen_q;
   assign bus.o_sram_addr_wr = wr_q;
   assign bus.o_sram_addr_rd = rd_q;
   assign bus.o_sram_d       = d_q;
   assign bus.o_win_valid    = wv_q;
   assign bus.o_coor_x       = ox_q;
   assign bus.o_coor_y       = oy_q;
   assign bus.o_start        = st_q;
   assign bus.o_end          = en_q;
   assign bus.o_busy         = busy_q;
endmodule
